// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, frame defaults
// and parity modes.
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_DATA_BITS    = 8;

  localparam int unsigned PARITY_MODE_EVEN = 0;
  localparam int unsigned PARITY_MODE_ODD  = 1;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // XOR of data and parity bit that a correct frame must produce.
  function automatic logic parity_target(input int unsigned mode);
    return (mode == PARITY_MODE_ODD);
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Sample-point counter for the UART receiver: free-runs modulo CLKS_PER_BIT and
// flags the half-period and full-period terminal counts.
module rx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tc_c,
  output logic full_tc_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == FULL_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tc_c = (cnt_q == HALF_LAST);
  assign full_tc_c = (cnt_q == FULL_LAST);

endmodule

// File: rtl/rx_sequencer.sv
// UART receive controller: start detection, mid-bit sampling, LSB-first shift,
// optional parity and stop check, valid/ready holding register with error pulses.
module rx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = PARITY_MODE_EVEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in_synced,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic PAR_TARGET = parity_target(PARITY_ODD);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 busy_q, busy_d;

  logic timer_clear_c;
  logic half_tc_c;
  logic full_tc_c;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear_c),
    .half_tc_c(half_tc_c),
    .full_tc_c(full_tc_c)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    par_acc_d     = par_acc_q;
    par_bad_d     = par_bad_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    framing_err_d = 1'b0;
    parity_err_d  = 1'b0;
    overrun_err_d = 1'b0;
    timer_clear_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_clear_c = 1'b1;
        if (!serial_in_synced) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (half_tc_c) begin
          timer_clear_c = 1'b1;
          if (serial_in_synced) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            par_acc_d = 1'b0;
            par_bad_d = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (full_tc_c) begin
          shreg_d   = {serial_in_synced, shreg_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ serial_in_synced;
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (full_tc_c) begin
          par_bad_d = ((par_acc_q ^ serial_in_synced) != PAR_TARGET);
          state_d   = ST_STOP;
        end
      end

      // Leaves at the stop mid-point so a back-to-back start edge is not missed.
      ST_STOP: begin
        if (full_tc_c) begin
          if (!serial_in_synced) begin
            framing_err_d = 1'b1;
            state_d       = ST_BREAK;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_err_d = 1'b1;
            end
          end
        end
      end

      ST_BREAK: begin
        timer_clear_c = 1'b1;
        if (serial_in_synced) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      par_acc_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      par_acc_q     <= par_acc_d;
      par_bad_q     <= par_bad_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// Scoreboard bench for rx_sequencer: a default instance (no parity) and an
// even-parity instance, each fed directed frames with hand-computed outcomes.
module tb_rx_sequencer;

  localparam int CPB    = 16;
  localparam int K_DATA = 0;
  localparam int K_FRM  = 1;
  localparam int K_PAR  = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int         ch;
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ser0  = 1'b1;
  logic ser1  = 1'b1;
  logic rdy0  = 1'b0;
  logic rdy1  = 1'b1;

  logic [7:0] data0, data1;
  logic v0, v1, fe0, fe1, pe0, pe1, oe0, oe1, busy0, busy1;

  rx_sequencer u_dut (
    .clk             (clk),
    .reset           (reset),
    .serial_in_synced(ser0),
    .rx_data         (data0),
    .rx_valid        (v0),
    .rx_ready        (rdy0),
    .framing_err     (fe0),
    .parity_err      (pe0),
    .overrun_err     (oe0),
    .busy            (busy0)
  );

  rx_sequencer #(
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) u_dut_par (
    .clk             (clk),
    .reset           (reset),
    .serial_in_synced(ser1),
    .rx_data         (data1),
    .rx_valid        (v1),
    .rx_ready        (rdy1),
    .framing_err     (fe1),
    .parity_err      (pe1),
    .overrun_err     (oe1),
    .busy            (busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  logic busy_hist[512];

  always @(negedge clk) busy_hist[cyc % 512] <= busy0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int ch, input int kind, input logic [7:0] data, input int at);
    exp_t e;
    e.ch   = ch;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic got(input int ch, input int kind, input logic [7:0] data);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got ch=%0d kind=%0d data=%02h at cycle %0d, want no event",
               ch, kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.ch != ch || e.kind != kind || e.data != data || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL sb_event: got ch=%0d kind=%0d data=%02h cyc=%0d, want ch=%0d kind=%0d data=%02h cyc=%0d",
                 ch, kind, data, cyc, e.ch, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: a presentation is rx_valid high unless it is the same frame still held.
  logic       mv[2], mf[2], mp[2], mo[2], mr[2], pv[2], pr[2];
  logic [7:0] md[2];
  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0; pr[0] = 1'b0; pr[1] = 1'b0;
  end

  always @(negedge clk) begin
    mv[0] = v0;  mv[1] = v1;
    mf[0] = fe0; mf[1] = fe1;
    mp[0] = pe0; mp[1] = pe1;
    mo[0] = oe0; mo[1] = oe1;
    mr[0] = rdy0; mr[1] = rdy1;
    md[0] = data0; md[1] = data1;
    if (mon_en) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (mv[ch] && !(pv[ch] && !pr[ch])) got(ch, K_DATA, md[ch]);
        if (mf[ch]) got(ch, K_FRM, md[ch]);
        if (mp[ch]) got(ch, K_PAR, md[ch]);
        if (mo[ch]) got(ch, K_OVR, md[ch]);
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
      pv[ch] = mv[ch];
      pr[ch] = mr[ch];
    end
  end

  task automatic drive_line(input int ch, input logic b);
    if (ch == 0) ser0 = b;
    else ser1 = b;
  endtask

  // Drives one frame; cycle 0 starts on entry. Optional ready pulse and reset at given cycles.
  task automatic send(input int ch, input logic [7:0] data, input bit par_en, input bit par_bit,
                      input bit stop_bit, input int rdy_at, input int rst_at);
    logic fb[11];
    int   nb;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = data[i];
    nb = 9;
    if (par_en) begin
      fb[nb] = par_bit;
      nb++;
    end
    fb[nb] = stop_bit;
    nb++;
    for (int n = 0; n < nb * CPB; n++) begin
      drive_line(ch, fb[n / CPB]);
      if (rdy_at >= 0) rdy0 = (n == rdy_at);
      if (n == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_line(ch, 1'b1);
        return;
      end
      tick();
    end
    if (rdy_at >= 0) rdy0 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;

    repeat (3) tick();
    check("reset_valid", 32'(v0), 32'd0);
    check("reset_data", 32'(data0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_errs", 32'({fe0, pe0, oe0}), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;

    // 1: clean frame, immediate consume
    rdy0 = 1'b1;
    t0 = cyc;
    expect_ev(0, K_DATA, 8'hA5, t0 + 153);
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
    check("t1_busy_at_152", 32'(busy_hist[(t0 + 152) % 512]), 32'd1);
    check("t1_busy_at_153", 32'(busy_hist[(t0 + 153) % 512]), 32'd0);

    // 2: short glitch rejected at the start mid-point
    t0 = cyc;
    ser0 = 1'b0;
    repeat (4) tick();
    ser0 = 1'b1;
    repeat (20) tick();
    check("t2_busy_at_8", 32'(busy_hist[(t0 + 8) % 512]), 32'd1);
    check("t2_busy_at_9", 32'(busy_hist[(t0 + 9) % 512]), 32'd0);

    // 3: bad stop bit, line held low, then recovery
    t0 = cyc;
    expect_ev(0, K_FRM, 8'hA5, t0 + 153);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (50) tick();
    check("t3_break_hold", 32'(busy0), 32'd1);
    ser0 = 1'b1;
    repeat (2) tick();
    check("t3_break_exit", 32'(busy0), 32'd0);
    t0 = cyc;
    expect_ev(0, K_DATA, 8'h55, t0 + 153);
    send(0, 8'h55, 1'b0, 1'b0, 1'b1, -1, -1);

    // 4: even parity, wrong then right parity bit
    t0 = cyc;
    expect_ev(1, K_PAR, 8'h00, t0 + 169);
    send(1, 8'h07, 1'b1, 1'b0, 1'b1, -1, -1);
    t0 = cyc;
    expect_ev(1, K_DATA, 8'h07, t0 + 169);
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, -1, -1);

    // 5: back-to-back with consumer stalled, then drain
    rdy0 = 1'b0;
    tick();
    t0 = cyc;
    expect_ev(0, K_DATA, 8'h11, t0 + 153);
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, -1, -1);
    t0 = cyc;
    expect_ev(0, K_OVR, 8'h11, t0 + 153);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, -1);
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    check("t5_drained", 32'(v0), 32'd0);
    tick();

    // 5 variant: ready exactly in the completing cycle replaces the held frame
    t0 = cyc;
    expect_ev(0, K_DATA, 8'h11, t0 + 153);
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, -1, -1);
    t0 = cyc;
    expect_ev(0, K_DATA, 8'h22, t0 + 153);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1, 152, -1);
    check("t5v_valid", 32'(v0), 32'd1);
    check("t5v_data", 32'(data0), 32'h22);

    // 6: reset mid-DATA with a frame still held
    t0 = cyc;
    send(0, 8'h96, 1'b0, 1'b0, 1'b1, -1, 60);
    check("t6_busy_pre", 32'(busy_hist[(t0 + 60) % 512]), 32'd1);
    check("t6_valid", 32'(v0), 32'd0);
    check("t6_data", 32'(data0), 32'd0);
    check("t6_busy", 32'(busy0), 32'd0);
    check("t6_errs", 32'({fe0, pe0, oe0}), 32'd0);
    repeat (4) tick();
    rdy0 = 1'b1;
    t0 = cyc;
    expect_ev(0, K_DATA, 8'hC3, t0 + 153);
    send(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1, -1);
    repeat (20) tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_pending: got %0d unmatched expected events, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
